// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Desc   : Shared constants and types for the single-issue RISC-V core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/pc_next.sv
// ============================================================================
// Module : pc_next
// Desc   : Next-PC mux of {hold, pc+4, aligned redirect target}.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            load,
  input  logic            is_ebreak,
  output logic [XLEN-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc & ~32'h0000_0003;
    end else if (load && !is_ebreak) begin
      next_pc = pc + 32'd4;
    end
  end

endmodule : pc_next

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module : instruction_fetch
// Desc   : PC register and fetch output register with valid/ready to decode.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            halted
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_instr;
  logic [XLEN-1:0] r_out_pc;
  logic            r_halted;

  logic            w_load;
  logic            w_is_ebreak;
  logic [XLEN-1:0] w_next_pc;

  assign w_load      = (r_state == RUN) && (!r_out_valid || out_ready);
  assign w_is_ebreak = (imem_instr == EBREAK_INSTR);

  pc_next u_pc_next (
    .pc             (r_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .load           (w_load),
    .is_ebreak      (w_is_ebreak),
    .next_pc        (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= NOP_INSTR;
      r_out_pc    <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      // Redirect flushes whatever is held and discards the word on imem_instr.
      if (redirect_valid) begin
        r_state     <= RUN;
        r_out_valid <= 1'b0;
        r_halted    <= 1'b0;
      end else if (w_load) begin
        r_out_instr <= imem_instr;
        r_out_pc    <= r_pc;
        r_out_valid <= 1'b1;
        if (w_is_ebreak) begin
          r_state  <= HALT;
          r_halted <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign halted    = r_halted;

endmodule : instruction_fetch

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module : tb_instruction_fetch
// Desc   : Directed plan plus random run of instruction_fetch against a model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  localparam logic [31:0] C_NOP    = 32'h0000_0013;
  localparam logic [31:0] C_EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  logic [31:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the architecturally visible state.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_opc;
  logic        m_halt;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[5:2]];

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return mem[addr[5:2]];
  endfunction

  task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] word;
    if (r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = C_NOP; m_opc = 32'h0; m_halt = 1'b0;
    end else if (rv) begin
      m_pc = {rpc[31:2], 2'b00}; m_valid = 1'b0; m_halt = 1'b0;
    end else if (!m_halt && (!m_valid || rdy)) begin
      word    = mem_word(m_pc);
      m_instr = word;
      m_opc   = m_pc;
      m_valid = 1'b1;
      if (word == C_EBREAK) m_halt = 1'b1;
      else                  m_pc   = m_pc + 32'd4;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string phase);
    check({phase, ".imem_addr"}, imem_addr, m_pc);
    check({phase, ".out_valid"}, {31'b0, out_valid}, {31'b0, m_valid});
    check({phase, ".out_instr"}, out_instr, m_instr);
    check({phase, ".out_pc"},    out_pc,    m_opc);
    check({phase, ".halted"},    {31'b0, halted}, {31'b0, m_halt});
  endtask

  task automatic cycle(input string phase, input logic r, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(posedge clk);
    model_step(r, rv, rpc, rdy);
    #1;
    compare_all(phase);
  endtask

  initial begin
    logic r, rv, rdy;
    logic [31:0] rpc;

    mem[0] = 32'hf0f0_a5a5;
    mem[1] = 32'h0000_0013;
    mem[2] = 32'hff00_ff00;
    mem[3] = C_EBREAK;
    for (int i = 4; i < 16; i++) mem[i] = $urandom() & 32'hFFFF_FF7F;
    mem[9] = C_EBREAK;

    // Reset then run
    cycle("t1_rst", 1'b1, 1'b0, 32'h0, 1'b1);
    cycle("t1_rst", 1'b1, 1'b0, 32'h0, 1'b1);
    check("t1_rst_instr", out_instr, 32'h0000_0013);
    for (int i = 0; i < 3; i++) cycle("t1_run", 1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_third_pc", out_pc, 32'h8);

    // Stall holding (8, ff00_ff00)
    for (int i = 0; i < 3; i++) cycle("t2_stall", 1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_stall_addr", imem_addr, 32'hC);
    cycle("t2_release", 1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_ebreak_word", out_instr, C_EBREAK);

    // EBREAK halt
    check("t3_halted", {31'b0, halted}, 32'h1);
    for (int i = 0; i < 6; i++) cycle("t3_halt", 1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_addr_held", imem_addr, 32'hC);

    // Redirect out of HALT to unaligned target
    cycle("t4_redir", 1'b0, 1'b1, 32'h0000_000A, 1'b1);
    check("t4_redir_addr", imem_addr, 32'h8);
    cycle("t4_target", 1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_target_word", out_instr, 32'hff00_ff00);

    // Redirect during stall flushes the held word
    cycle("t5_to4", 1'b0, 1'b1, 32'h4, 1'b1);
    cycle("t5_load4", 1'b0, 1'b0, 32'h0, 1'b0);
    cycle("t5_flush", 1'b0, 1'b1, 32'h0, 1'b0);
    cycle("t5_first", 1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_first_pc", out_pc, 32'h0);

    // Reset wins over a simultaneous redirect
    cycle("t6_run", 1'b0, 1'b0, 32'h0, 1'b1);
    cycle("t6_rst", 1'b1, 1'b1, 32'h8, 1'b1);
    check("t6_rst_addr", imem_addr, 32'h0);
    cycle("t6_first", 1'b0, 1'b0, 32'h0, 1'b1);

    // Address wrap at the top of the address space
    cycle("t7_top", 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    cycle("t7_load", 1'b0, 1'b0, 32'h0, 1'b1);
    check("t7_wrap_addr", imem_addr, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      else                           rpc = $urandom_range(0, 63);
      cycle("rand", r, rv, rpc, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instruction_fetch

`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and fetch stage of the single-issue RISC-V core. It drives the address of the combinational `InstructionMemory` and captures the returned word together with its PC into a fetch output register. It presents that register to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute and stops fetching after an EBREAK.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.

**Ports**
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  address to `InstructionMemory.addr`; combinational copy of internal `pc`.
- `imem_instr`  in  32  word from `InstructionMemory.instr`; valid in the same cycle as `imem_addr` (async read).
- `redirect_valid`  in  1  execute requests a PC change this cycle.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored and treated as 2'b00.
- `out_valid`  out  1  fetch register holds an instruction for decode.
- `out_ready`  in  1  decode accepts the fetch register this cycle.
- `out_instr`  out  32  fetched instruction.
- `out_pc`  out  32  address `out_instr` was fetched from.
- `halted`  out  1  EBREAK fetched; no further fetches until redirect or reset.

## Operation
- **States:** `RUN`, `HALT`.
- **Reset values:**
  - `pc`=RESET_PC, state=`RUN`
  - `out_valid`=0, `out_instr`=32'h0000_0013 (NOP), `out_pc`=32'h0
  - `halted`=0
- **Load condition:** `load = (state==RUN) && (!out_valid || out_ready)`.
  - On load, at the edge: `out_instr`<=`imem_instr`, `out_pc`<=`pc`, `out_valid`<=1, `pc`<=`pc`+4.
- **Addition:** 32-bit, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- **No load, output consumed:** if there is no load and `out_valid && out_ready`, then `out_valid`<=0.
- **Stall:** `out_valid && !out_ready` holds `pc`, `out_instr` and `out_pc` unchanged.
- **EBREAK:**
  - If the loaded word equals 32'h0010_0073, it is still delivered.
  - On the same edge: state<=`HALT`, `halted`<=1, and `pc` does not advance (holds the EBREAK address).
  - In `HALT`: no loads. `out_valid` clears once the EBREAK is consumed.
- **Redirect** (priority over load, stall and HALT), at the edge:
  - `pc`<={`redirect_pc`[31:2],2'b00}, `out_valid`<=0, state<=`RUN`, `halted`<=0.
  - The word currently on `imem_instr` is discarded.
  - A held, unconsumed `out_instr` is flushed.
- **Priority:** `rst` > `redirect_valid` > load/consume logic.

## Timing
- **Fetch latency:** 1 cycle. `pc` presented in cycle N appears on `out_instr` after edge N.
- **First instruction:** after `rst` deasserts, the first rising edge loads from RESET_PC, so `out_valid`=1 one cycle after reset release.
- **Throughput:** 1 instruction/cycle while `out_ready`=1.
- **Redirect penalty:**
  - `redirect_valid` in cycle N: after edge N, `pc`=target and `out_valid`=0.
  - After edge N+1, target instruction is valid. Exactly one bubble.
- **Handshake:** `out_valid`/`out_instr`/`out_pc` are registered only; no combinational path from `out_ready` to them. `imem_addr` depends only on the `pc` register.
- **`rst` during stall, HALT or redirect:** outputs reach reset values at that edge. The redirect is dropped.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` = 32'h0000_0013
  - `EBREAK_INSTR` = 32'h0010_0073
  - `XLEN` = 32
  - fetch state enum {`RUN`, `HALT`}
- One sub-module: `pc_next`. Combinational next-PC mux of {hold, pc+4, aligned redirect}, selected by the priority rules above.
- `InstructionMemory` is instantiated by the parent core, not inside this block.

## Test plan
Bench instantiates `InstructionMemory` with word 0 = 32'hf0f0_a5a5, word 1 = 32'h0000_0013, word 2 = 32'hff00_ff00, word 3 = 32'h0010_0073, RESET_PC=0.

1. **Reset then run:** 2 cycles `rst`=1, `out_ready`=1.
   - During reset: `out_valid`=0, `out_instr`=32'h13, `imem_addr`=0.
   - Then successive accepts: (pc 0, f0f0_a5a5), (4, 0000_0013), (8, ff00_ff00).
2. **Stall:** `out_ready`=0 for 3 cycles while holding (8, ff00_ff00).
   - Outputs and `imem_addr`=12 stay constant.
   - Release: next accepted is (12, 0010_0073).
3. **EBREAK halt:**
   - After (12, 0010_0073) is loaded: `halted`=1, `imem_addr` stays 12.
   - After it is consumed, `out_valid`=0 and stays 0 for 5 cycles.
4. **Redirect from HALT:** `redirect_valid`=1, `redirect_pc`=32'h0000_000A.
   - Next cycle: `imem_addr`=8, `halted`=0, `out_valid`=0.
   - Following cycle: (8, ff00_ff00) valid.
5. **Redirect during stall:** with (4, 0000_0013) held and `out_ready`=0, pulse redirect to 0.
   - Held word is flushed (never accepted).
   - Next delivered is (0, f0f0_a5a5) after one bubble.
6. **Reset priority:** assert `rst` and `redirect_valid` (target 8) in the same cycle mid-run.
   - All outputs return to reset values and `imem_addr`=0.
   - First fetch after release is (0, f0f0_a5a5).
